// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the CPU core: register indices, hazard FSM states
// and the latch-control bundle produced by the hazard unit.
package cpu_types_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned STALL_CNT_W = 16;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } latch_ctrl_t;

    // EX-stage load whose destination feeds an ID-stage source; r0 never hazards.
    function automatic logic is_load_use(input logic     idex_dren,
                                         input regbits_t idex_wsel,
                                         input regbits_t ifid_rs,
                                         input regbits_t ifid_rt);
        return idex_dren && (idex_wsel != '0) &&
               ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
    endfunction

    // Pipeline control once memory is not holding the core (redirect > load-use > imiss).
    function automatic latch_ctrl_t run_rules(input logic redirect,
                                              input logic load_use,
                                              input logic ihit);
        latch_ctrl_t c;
        c = '0;
        if (redirect) begin
            c.pc_en      = ihit;
            c.ifid_en    = 1'b1;
            c.idex_en    = 1'b1;
            c.exmem_en   = 1'b1;
            c.memwb_en   = 1'b1;
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (load_use) begin
            c.idex_en    = 1'b1;
            c.exmem_en   = 1'b1;
            c.memwb_en   = 1'b1;
            c.idex_flush = 1'b1;
        end else if (ihit) begin
            c.pc_en    = 1'b1;
            c.ifid_en  = 1'b1;
            c.idex_en  = 1'b1;
            c.exmem_en = 1'b1;
            c.memwb_en = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/forward_unit_if.sv
// Operand-forwarding bundle between the pipeline datapath and the forwarding unit.
interface forward_unit_if;
    import cpu_types_pkg::*;

    regbits_t    idex_rs;
    regbits_t    idex_rt;
    regbits_t    exmem_wsel;
    regbits_t    memwb_wsel;
    logic        exmem_wen;
    logic        memwb_wen;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;

    modport fu (
        input  idex_rs, idex_rt, exmem_wsel, memwb_wsel, exmem_wen, memwb_wen,
        output forward_a, forward_b
    );

    modport cpu (
        output idex_rs, idex_rt, exmem_wsel, memwb_wsel, exmem_wen, memwb_wen,
        input  forward_a, forward_b
    );
endinterface

// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: pipeline status in, latch enables/flushes and status out.
interface hazard_unit_if;
    import cpu_types_pkg::*;

    logic                   ihit;
    logic                   dhit;
    logic                   exmem_dREN;
    logic                   exmem_dWEN;
    logic                   idex_dREN;
    regbits_t               idex_wsel;
    regbits_t               ifid_rs;
    regbits_t               ifid_rt;
    logic                   ex_branch_taken;
    logic                   ex_jump;
    logic                   memwb_halt;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   idex_en;
    logic                   exmem_en;
    logic                   memwb_en;
    logic                   ifid_flush;
    logic                   idex_flush;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport hu (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_wsel,
               ifid_rs, ifid_rt, ex_branch_taken, ex_jump, memwb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, stall_cnt
    );

    modport cpu (
        output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_wsel,
               ifid_rs, ifid_rt, ex_branch_taken, ex_jump, memwb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory-wait/halt FSM, combinational latch control and
// a saturating count of cycles in which the PC is held.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    hazard_unit_if.hu  hif
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    hazard_state_t          state;
    hazard_state_t          state_next;
    latch_ctrl_t            ctrl;
    logic                   halted_c;
    logic                   load_use_c;
    logic                   redirect_c;
    logic                   mem_pending_c;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign load_use_c    = is_load_use(hif.idex_dREN, hif.idex_wsel, hif.ifid_rs, hif.ifid_rt);
    assign redirect_c    = hif.ex_branch_taken | hif.ex_jump;
    assign mem_pending_c = hif.exmem_dREN | hif.exmem_dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        ctrl       = '0;
        state_next = state;
        halted_c   = 1'b0;
        if (!RST) begin
            unique case (state)
                RUN: begin
                    if (mem_pending_c && !hif.dhit) begin
                        state_next = MEMWAIT;
                    end else begin
                        ctrl = run_rules(redirect_c, load_use_c, hif.ihit);
                    end
                end
                MEMWAIT: begin
                    // Access completing this cycle counts as the memory term satisfied.
                    if (hif.dhit) begin
                        ctrl       = run_rules(redirect_c, load_use_c, hif.ihit);
                        state_next = RUN;
                    end
                end
                HALT: begin
                    halted_c = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
            // Halt retiring through WB overrides any other transition.
            if ((state != HALT) && hif.memwb_halt && ctrl.memwb_en) begin
                state_next = HALT;
            end
        end
    end

    // Stall performance counter, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if ((state != HALT) && !ctrl.pc_en && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign hif.pc_en      = ctrl.pc_en;
    assign hif.ifid_en    = ctrl.ifid_en;
    assign hif.idex_en    = ctrl.idex_en;
    assign hif.exmem_en   = ctrl.exmem_en;
    assign hif.memwb_en   = ctrl.memwb_en;
    assign hif.ifid_flush = ctrl.ifid_flush;
    assign hif.idex_flush = ctrl.idex_flush;
    assign hif.halted     = halted_c;
    assign hif.stall_cnt  = stall_cnt_q;

endmodule
